// File: rtl/pipelined_approx_multiplier.sv
// 3-stage pipelined unsigned WIDTHxWIDTH multiplier with valid/ready handshake and optional
// low-column truncation. Define APPROX_MUL_EXACT_MODE_EN to honour the per-transaction mode input.
module pipelined_approx_multiplier #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_COLS = 6
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     product,
    output logic                   out_mode,
    output logic [15:0]            op_count
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned NG = (WIDTH + 3) / 4;
    localparam int unsigned NR = 2 * NG;
    localparam logic [PW-1:0] APPROX_MASK = ~((PW'(1) << APPROX_COLS) - PW'(1));
    localparam logic [PW-1:0] COMP_BIT    = PW'(1) << (APPROX_COLS - 1);

    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic s2_ok_c, s3_ok_c, s3_move_c;
    logic mode_eff_c;

    logic [PW-1:0] s1_rows_d [NR];
    logic [PW-1:0] s1_rows_q [NR];
    logic          mode1_q;
    logic [PW-1:0] sum2_d, carry2_d;
    logic [PW-1:0] sum2_q, carry2_q;
    logic          mode2_q;
    logic [PW-1:0] sum3_c;
    logic [PW-1:0] product_d, product_q;
    logic          out_mode_d, out_mode_q;
    logic [15:0]   op_count_d, op_count_q;
    logic          cnt_en_c;

`ifdef APPROX_MUL_EXACT_MODE_EN
    assign mode_eff_c = mode;
`else
    // Exact path is compiled out; mode is intentionally ignored.
    logic unused_mode;
    assign unused_mode = mode;
    assign mode_eff_c  = 1'b1;
`endif

    // Backward readiness: a stage may load when empty or when it drains this cycle.
    assign s3_move_c = v3_q & out_ready;
    assign s3_ok_c   = ~v3_q | out_ready;
    assign s2_ok_c   = ~v2_q | (v2_q & s3_ok_c);
    assign in_ready  = ~v1_q | (v1_q & s2_ok_c);

    // Stage 1: masked partial products, padded to a multiple of four rows.
    logic [PW-1:0] pp_c [4*NG];
    for (genvar j = 0; j < 4 * NG; j++) begin : g_pp
        if (j < WIDTH) begin : g_row
            logic [PW-1:0] row;
            assign row      = b[j] ? (PW'(a) << j) : '0;
            assign pp_c[j]  = mode_eff_c ? (row & APPROX_MASK) : row;
        end else begin : g_pad
            assign pp_c[j] = '0;
        end
    end

    // First level: one 4:2 compressor (two chained full-adder rows) per group of four rows.
    for (genvar g = 0; g < NG; g++) begin : g_c42
        logic [PW-1:0] w0, w1, w2, w3, s_a, c_a;
        assign w0  = pp_c[4*g];
        assign w1  = pp_c[4*g+1];
        assign w2  = pp_c[4*g+2];
        assign w3  = pp_c[4*g+3];
        assign s_a = w0 ^ w1 ^ w2;
        assign c_a = ((w0 & w1) | (w0 & w2) | (w1 & w2)) << 1;
        assign s1_rows_d[2*g]   = s_a ^ c_a ^ w3;
        assign s1_rows_d[2*g+1] = ((s_a & c_a) | (s_a & w3) | (c_a & w3)) << 1;
    end

    // Stage 2: carry-save reduction of the remaining rows down to sum and carry.
    for (genvar r = 0; r < NR - 1; r++) begin : g_red
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        if (r == 0) begin : g_base
            assign s = s1_rows_q[0];
            assign c = s1_rows_q[1];
        end else begin : g_csa
            logic [PW-1:0] x, y, z;
            assign x = g_red[r-1].s;
            assign y = g_red[r-1].c;
            assign z = s1_rows_q[r+1];
            assign s = x ^ y ^ z;
            assign c = ((x & y) | (x & z) | (y & z)) << 1;
        end
    end
    assign sum2_d   = g_red[NR-2].s;
    assign carry2_d = g_red[NR-2].c;

    // Stage 3: carry-propagate add plus compensation constant in the truncated columns.
    assign sum3_c = sum2_q + carry2_q;

    always_comb begin
        v1_d       = v1_q;
        v2_d       = v2_q;
        v3_d       = v3_q;
        product_d  = product_q;
        out_mode_d = out_mode_q;
        op_count_d = op_count_q;
        cnt_en_c   = 1'b0;

        if (in_ready) v1_d = in_valid;
        if (s2_ok_c)  v2_d = v1_q;
        if (s3_ok_c)  v3_d = v2_q;

        if (s3_ok_c && v2_q) begin
`ifdef APPROX_MUL_EXACT_MODE_EN
            product_d = mode2_q ? ((sum3_c & APPROX_MASK) | COMP_BIT) : sum3_c;
`else
            product_d = (sum3_c & APPROX_MASK) | COMP_BIT;
`endif
            out_mode_d = mode2_q;
        end

`ifdef APPROX_MUL_EXACT_MODE_EN
        cnt_en_c = s3_move_c & out_mode_q;
`else
        cnt_en_c = s3_move_c;
`endif
        if (cnt_en_c && (op_count_q != 16'hFFFF)) op_count_d = op_count_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            product_q  <= '0;
            out_mode_q <= 1'b0;
            op_count_q <= '0;
        end else begin
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            v3_q       <= v3_d;
            product_q  <= product_d;
            out_mode_q <= out_mode_d;
            op_count_q <= op_count_d;
        end
    end

    // Datapath registers carry no reset; the valid bits qualify them.
    always_ff @(posedge CLK) begin
        if (in_ready && in_valid) begin
            s1_rows_q <= s1_rows_d;
            mode1_q   <= mode_eff_c;
        end
        if (s2_ok_c && v1_q) begin
            sum2_q   <= sum2_d;
            carry2_q <= carry2_d;
            mode2_q  <= mode1_q;
        end
    end

    assign out_valid = v3_q;
    assign product   = product_q;
    assign out_mode  = out_mode_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_pipelined_approx_multiplier.sv
// Directed bench for pipelined_approx_multiplier (WIDTH=8, K=6); honours APPROX_MUL_EXACT_MODE_EN.
module tb_pipelined_approx_multiplier;

    localparam int unsigned W = 8;
    localparam int unsigned K = 6;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] product;
    logic          out_mode;
    logic [15:0]   op_count;

    pipelined_approx_multiplier #(.WIDTH(W), .APPROX_COLS(K)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .out_mode(out_mode), .op_count(op_count)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_opcnt = 0;
    int tx = 0;
    int cyc = 0;
    int n_del = 0;
    int prev_del = 0;
    int gaps = 0;
    logic [15:0] last_prod;
    logic [15:0] exp_q[$];
    logic        expm_q[$];
    logic [7:0]  sa [32];
    logic [7:0]  sb [32];
    logic        sm [32];

    // Hand-computed directed vectors: a, b, mode, exact product, approximate product (K=6).
    logic [7:0]  dv_a [9] = '{8'd255, 8'd255, 8'd0, 8'd3, 8'd128, 8'd1, 8'd12, 8'd200, 8'd16};
    logic [7:0]  dv_b [9] = '{8'd255, 8'd255, 8'd0, 8'd5, 8'd128, 8'd255, 8'd10, 8'd100, 8'd16};
    logic        dv_m [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] dv_ex [9] = '{16'd65025, 16'd65025, 16'd0, 16'd15, 16'd16384, 16'd255, 16'd120, 16'd20000, 16'd256};
    logic [15:0] dv_ap [9] = '{16'd64736, 16'd64736, 16'd32, 16'd32, 16'd16416, 16'd224, 16'd96, 16'd20000, 16'd288};

    function automatic logic eff_mode(input logic m);
`ifdef APPROX_MUL_EXACT_MODE_EN
        return m;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [15:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic m);
        logic [15:0] s;
        s = '0;
        if (eff_mode(m)) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    if (ma[i] && mb[j] && (i + j) >= int'(K)) s = s + (16'd1 << (i + j));
            s = s | (16'd1 << (K - 1));
        end else begin
            s = 16'(ma) * 16'(mb);
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // One cycle of streaming: drive next stimulus, score any output transfer, advance.
    task automatic step_io(input logic ordy, input int limit);
        logic acc, del;
        if (tx < limit) begin
            in_valid = 1'b1; a = sa[tx]; b = sb[tx]; mode = sm[tx];
        end else begin
            in_valid = 1'b0;
        end
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        del = out_valid && out_ready;
        if (del) begin
            check("output_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("stream_product", product, exp_q[0]);
                check("stream_out_mode", out_mode, expm_q[0]);
                if (expm_q[0] && exp_opcnt < 65535) exp_opcnt++;
                void'(exp_q.pop_front());
                void'(expm_q.pop_front());
            end
            if (n_del > 0 && cyc != prev_del + 1) gaps++;
            prev_del  = cyc;
            last_prod = product;
            n_del++;
        end
        if (acc) begin
            exp_q.push_back(model(sa[tx], sb[tx], sm[tx]));
            expm_q.push_back(eff_mode(sm[tx]));
            tx++;
        end
        tick();
    endtask

    initial begin
        logic [15:0] held;
        logic        have;
        logic [15:0] exp_p;
        RST_N = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_product", product, 0);
        check("rst_op_count", op_count, 0);
        tick();
        RST_N = 1'b1;
        tick();

        // Single transactions: latency, value, mode tag and counter.
        for (int k = 0; k < 9; k++) begin
            a = dv_a[k]; b = dv_b[k]; mode = dv_m[k]; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            check("accept_ready", in_ready, 1);
            tick();
            in_valid = 1'b0;
            check("lat_edge1", out_valid, 0);
            tick();
            check("lat_edge2", out_valid, 0);
            tick();
            exp_p = eff_mode(dv_m[k]) ? dv_ap[k] : dv_ex[k];
            check("lat_edge3_valid", out_valid, 1);
            check("dir_product", product, exp_p);
            check("dir_out_mode", out_mode, eff_mode(dv_m[k]));
            tick();
            if (eff_mode(dv_m[k])) exp_opcnt++;
            check("dir_op_count", op_count, exp_opcnt);
            check("dir_drained", out_valid, 0);
        end

        // Back-to-back stream of 10 random pairs at full rate.
        for (int i = 0; i < 10; i++) begin
            sa[i] = 8'($urandom_range(0, 255));
            sb[i] = 8'($urandom_range(0, 255));
            sm[i] = 1'($urandom_range(0, 1));
        end
        tx = 0; n_del = 0; gaps = 0;
        for (int c = 0; c < 40 && (tx < 10 || exp_q.size() > 0); c++) step_io(1'b1, 10);
        check("stream_count", n_del, 10);
        check("stream_gaps", gaps, 0);
        check("stream_queue_empty", exp_q.size(), 0);
        check("stream_op_count", op_count, exp_opcnt);

        // Stall: out_ready low for 6 cycles with in_valid held high.
        for (int i = 0; i < 6; i++) begin
            sa[i] = 8'(17 * i + 40); sb[i] = 8'(29 * i + 3); sm[i] = i[0];
        end
        tx = 0; n_del = 0; gaps = 0; have = 1'b0; held = '0;
        for (int c = 0; c < 6; c++) begin
            step_io(1'b0, 6);
            if (out_valid) begin
                if (!have) begin
                    held = product; have = 1'b1;
                end else begin
                    check("stall_hold", product, held);
                end
            end
        end
        check("stall_accepts", tx, 3);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("release_ready_same_cycle", in_ready, 1);
        step_io(1'b1, 4);
        check("full_swap_accepts", tx, 4);
        check("full_swap_delivered", n_del, 1);
        check("full_swap_out_valid", out_valid, 1);
        for (int c = 0; c < 12 && exp_q.size() > 0; c++) step_io(1'b1, 4);
        check("drain_count", n_del, 4);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_no_dup", out_valid, 0);
        check("drain_op_count", op_count, exp_opcnt);

        // Asynchronous reset with two items in flight.
        sa[0] = 8'd7; sb[0] = 8'd9; sm[0] = 1'b1;
        sa[1] = 8'd99; sb[1] = 8'd77; sm[1] = 1'b0;
        tx = 0;
        step_io(1'b0, 2);
        step_io(1'b0, 2);
        in_valid = 1'b0;
        RST_N = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_op_count", op_count, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete(); expm_q.delete(); exp_opcnt = 0;
        tick();
        RST_N = 1'b1;
        tick();
        sa[0] = 8'd3; sb[0] = 8'd5; sm[0] = 1'b0;
        tx = 0; n_del = 0; last_prod = '0;
        for (int c = 0; c < 12 && (tx < 1 || exp_q.size() > 0); c++) step_io(1'b1, 1);
        check("post_rst_count", n_del, 1);
`ifdef APPROX_MUL_EXACT_MODE_EN
        check("post_rst_3x5", last_prod, 15);
`else
        check("post_rst_3x5", last_prod, 32);
`endif
        check("post_rst_op_count", op_count, exp_opcnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
